// File: rtl/tcnt_gen_pkg.sv
// Shared constants and FSM encoding for the pulse timing generator and the
// downstream phase path.
package tcnt_gen_pkg;

  localparam int TCNT_TW        = 27;
  localparam int TCNT_LW        = 16;
  localparam int CMD_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } tcnt_state_t;

endpackage

// File: rtl/tcnt_gen_cmd_fifo2.sv
// Two-entry command FIFO with a registered ready: a push while full is refused
// even when a pop happens in the same cycle.
module cmd_fifo2
  import tcnt_gen_pkg::*;
#(
  parameter int DW = 8,
  localparam int LVL_W = $clog2(CMD_FIFO_DEPTH + 1),
  localparam int PW    = $clog2(CMD_FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head_data,
  output logic             empty,
  output logic [LVL_W-1:0] level_next
);

  logic [DW-1:0]    mem [CMD_FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & ~empty;
  assign empty      = (level_q == '0);
  assign level_next = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  assign head_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      push_ready <= 1'b0;
    end else begin
      level_q    <= level_next;
      push_ready <= (level_next != LVL_W'(CMD_FIFO_DEPTH));
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; level_q guards every read, so
  // stale entries are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tcnt_gen.sv
// Timed pulse generator: free-running time base, command FIFO and an
// IDLE/ARM/RUN sequencer producing gate, tcnt and freq for the phase path.
module tcnt_gen
  import tcnt_gen_pkg::*;
#(
  parameter int TW = TCNT_TW,
  parameter int LW = TCNT_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [TW-1:0] cmd_time,
  input  logic [LW-1:0] cmd_len,
  input  logic [TW-1:0] cmd_freq,
  input  logic          cmd_coh,
  output logic [TW-1:0] tnow,
  output logic [TW-1:0] tcnt,
  output logic [TW-1:0] freq,
  output logic          gate,
  output logic          done,
  output logic          late_err,
  output logic          busy
);

  localparam int CW    = 2 * TW + LW + 1;
  localparam int LVL_W = $clog2(CMD_FIFO_DEPTH + 1);

  logic [CW-1:0]    head_data;
  logic             fifo_empty;
  logic [LVL_W-1:0] level_next;
  logic             pop;
  logic [TW-1:0]    h_time, h_freq;
  logic [LW-1:0]    h_len;
  logic             h_coh;

  cmd_fifo2 #(.DW(CW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  ({cmd_coh, cmd_freq, cmd_len, cmd_time}),
    .pop        (pop),
    .head_data  (head_data),
    .empty      (fifo_empty),
    .level_next (level_next)
  );

  assign {h_coh, h_freq, h_len, h_time} = head_data;

  tcnt_state_t   state_q, state_d;
  logic [TW-1:0] act_time_q, act_time_d, act_freq_q, act_freq_d;
  logic [LW-1:0] act_len_q, act_len_d, cnt_q, cnt_d;
  logic          act_coh_q, act_coh_d;
  logic [TW-1:0] tcnt_d, freq_d;
  logic          gate_d, done_d, late_d, busy_d;
  logic          take_head, start, start_late;

  // Lead is measured against the tnow value at which gate would first be high
  // if the pulse started now; a negative wrap-aware lead means late.
  logic [TW-1:0] tnow_nx, head_lead, act_lead;
  logic          head_due, head_late, act_due, act_late;

  assign tnow_nx   = tnow + 1'b1;
  assign head_lead = h_time - tnow_nx;
  assign act_lead  = act_time_q - tnow_nx;
  assign head_late = head_lead[TW-1];
  assign head_due  = head_late | (head_lead == '0);
  assign act_late  = act_lead[TW-1];
  assign act_due   = act_late | (act_lead == '0);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    act_time_d = act_time_q;
    act_len_d  = act_len_q;
    act_freq_d = act_freq_q;
    act_coh_d  = act_coh_q;
    cnt_d      = cnt_q;
    gate_d     = 1'b0;
    tcnt_d     = '0;
    freq_d     = freq;
    done_d     = 1'b0;
    late_d     = 1'b0;
    pop        = 1'b0;
    take_head  = 1'b0;
    start      = 1'b0;
    start_late = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          take_head = 1'b1;
          if (h_len == '0) begin
            done_d = 1'b1;
          end else if (head_due) begin
            start      = 1'b1;
            start_late = head_late;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (act_due) begin
          start      = 1'b1;
          start_late = act_late;
        end
      end
      ST_RUN: begin
        if (cnt_q != act_len_q - 1'b1) begin
          gate_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          tcnt_d = act_coh_q ? tnow_nx : TW'(cnt_q + 1'b1);
        end else begin
          // Last gate cycle: chain straight into the prefetched head when it
          // is due, so back-to-back pulses leave no gap. Zero-length heads
          // are left for IDLE so their done never collides with this one.
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (!fifo_empty && h_len != '0) begin
            take_head = 1'b1;
            if (head_due) begin
              start      = 1'b1;
              start_late = head_late;
            end else begin
              state_d = ST_ARM;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_head) begin
      pop        = 1'b1;
      act_time_d = h_time;
      act_len_d  = h_len;
      act_freq_d = h_freq;
      act_coh_d  = h_coh;
    end

    if (start) begin
      state_d = ST_RUN;
      gate_d  = 1'b1;
      cnt_d   = '0;
      tcnt_d  = act_coh_d ? tnow_nx : '0;
      freq_d  = act_freq_d;
      late_d  = start_late;
    end

    busy_d = (state_d != ST_IDLE) || (level_next != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      act_time_q <= '0;
      act_len_q  <= '0;
      act_freq_q <= '0;
      act_coh_q  <= 1'b0;
      cnt_q      <= '0;
      tnow       <= '0;
      tcnt       <= '0;
      freq       <= '0;
      gate       <= 1'b0;
      done       <= 1'b0;
      late_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_time_q <= act_time_d;
      act_len_q  <= act_len_d;
      act_freq_q <= act_freq_d;
      act_coh_q  <= act_coh_d;
      cnt_q      <= cnt_d;
      tnow       <= tnow_nx;
      tcnt       <= tcnt_d;
      freq       <= freq_d;
      gate       <= gate_d;
      done       <= done_d;
      late_err   <= late_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_tcnt_gen.sv
// Scoreboard bench for tcnt_gen: expected gate/done events are queued at
// command push and matched against the DUT at each falling clock edge.
module tb_tcnt_gen;

  localparam int TW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [TW-1:0] cmd_time = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [TW-1:0] cmd_freq = '0;
  logic          cmd_coh = 1'b0;
  logic [TW-1:0] tnow, tcnt, freq;
  logic          gate, done, late_err, busy;

  tcnt_gen #(.TW(TW), .LW(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_time  (cmd_time),
    .cmd_len   (cmd_len),
    .cmd_freq  (cmd_freq),
    .cmd_coh   (cmd_coh),
    .tnow      (tnow),
    .tcnt      (tcnt),
    .freq      (freq),
    .gate      (gate),
    .done      (done),
    .late_err  (late_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [TW-1:0] tc;
    logic [TW-1:0] f;
  } gate_exp_t;

  typedef struct packed {
    logic          any_time;
    logic [TW-1:0] t;
  } done_exp_t;

  gate_exp_t gate_q[$];
  done_exp_t done_q[$];
  int        n_checks = 0;
  int        n_errors = 0;
  bit        sb_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_cmd(input logic [TW-1:0] t, input logic [LW-1:0] l,
                          input logic [TW-1:0] f, input logic coh, input bit track,
                          output logic [TW-1:0] acc);
    gate_exp_t ge;
    done_exp_t de;
    cmd_valid = 1'b1;
    cmd_time  = t;
    cmd_len   = l;
    cmd_freq  = f;
    cmd_coh   = coh;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) check("push_timeout", cmd_ready, 1'b1);
    acc = tnow;
    if (track) begin
      for (int i = 0; i < int'(l); i++) begin
        ge.t  = t + TW'(i);
        ge.tc = coh ? t + TW'(i) : TW'(i);
        ge.f  = f;
        gate_q.push_back(ge);
      end
      de.any_time = (l == '0);
      de.t        = t + TW'(l);
      done_q.push_back(de);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tnow(input logic [TW-1:0] target);
    for (int i = 0; i < 3000 && tnow != target; i++) @(negedge clk);
    check("wait_tnow", tnow, target);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (gate_q.size() != 0 || done_q.size() != 0 || busy); i++)
      @(negedge clk);
    check("drain_gate_q", gate_q.size(), 0);
    check("drain_done_q", done_q.size(), 0);
    check("drain_busy", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    gate_exp_t ge;
    done_exp_t de;
    if (!reset && sb_en) begin
      if (gate) begin
        if (gate_q.size() == 0) check("gate_extra", gate, 1'b0);
        else begin
          ge = gate_q.pop_front();
          check("gate_tnow", tnow, ge.t);
          check("gate_tcnt", tcnt, ge.tc);
          check("gate_freq", freq, ge.f);
        end
      end else begin
        check("idle_tcnt", tcnt, '0);
      end
      if (done) begin
        if (done_q.size() == 0) check("done_extra", done, 1'b0);
        else begin
          de = done_q.pop_front();
          if (de.any_time) check("done_len0_gate", gate, 1'b0);
          else             check("done_tnow", tnow, de.t);
        end
      end
      if (late_err) check("late_spurious", late_err, 1'b0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [TW-1:0] acc, base, first_t, last_t, done_t;
  int            n_gate, n_late, n_done;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_tnow", tnow, '0);
    check("rst_gate", gate, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tcnt", tcnt, '0);
    check("rst_freq", freq, '0);
    check("rst_done", done, 1'b0);
    check("rst_late", late_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);
    check("tnow_first", tnow, 1);

    // Basic non-coherent pulse at a fixed time.
    wait_tnow(2);
    push_cmd(10, 4, 100, 1'b0, 1'b1, acc);
    drain();

    // Back-to-back coherent pulses: continuous gate, freq switch, two dones.
    base = tnow + 8;
    push_cmd(base, 5, 200, 1'b1, 1'b1, acc);
    push_cmd(base + 5, 3, 300, 1'b1, 1'b1, acc);
    drain();

    // Late start: start time already passed at acceptance.
    sb_en = 1'b0;
    push_cmd(tnow - 3, 2, 50, 1'b0, 1'b0, acc);
    n_gate = 0; n_late = 0; n_done = 0;
    first_t = '0; last_t = '0; done_t = '0;
    for (int i = 0; i < 10; i++) begin
      if (gate) begin
        if (n_gate == 0) first_t = tnow;
        check("late_tcnt", tcnt, n_gate);
        last_t = tnow;
        n_gate++;
      end
      if (late_err) n_late++;
      if (done) begin
        done_t = tnow;
        n_done++;
      end
      @(negedge clk);
    end
    check("late_pulses", n_late, 1);
    check("late_gate_len", n_gate, 2);
    check("late_start_within_2", TW'(first_t - acc) <= 2, 1'b1);
    check("late_done_count", n_done, 1);
    check("late_done_after_gate", done_t, last_t + 1'b1);
    check("late_idle_busy", busy, 1'b0);
    sb_en = 1'b1;

    // Three queued commands: FIFO fills while the first is armed.
    base = tnow;
    push_cmd(base + 20, 2, 11, 1'b0, 1'b1, acc);
    push_cmd(base + 24, 2, 12, 1'b0, 1'b1, acc);
    push_cmd(base + 28, 2, 13, 1'b0, 1'b1, acc);
    check("ready_full", cmd_ready, 1'b0);
    check("busy_full", busy, 1'b1);
    wait_tnow(base + 21);
    check("ready_held", cmd_ready, 1'b0);
    @(negedge clk);
    check("ready_after_pop", cmd_ready, 1'b1);
    drain();

    // Zero-length command with a past start time: done only, no late_err.
    push_cmd(tnow - 5, 0, 77, 1'b0, 1'b1, acc);
    drain();
    check("freq_hold", freq, 13);

    // Reset in the third gate cycle with a second command still queued.
    sb_en = 1'b0;
    push_cmd(tnow + 8, 5, 40, 1'b0, 1'b0, acc);
    push_cmd(tnow + 30, 2, 41, 1'b0, 1'b0, acc);
    for (int i = 0; i < 50 && !(gate && tcnt == 2); i++) @(negedge clk);
    check("abort_third_cycle", tcnt, 2);
    #2 reset = 1'b1;
    #1;
    check("abort_gate_async", gate, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_fifo_empty", busy, 1'b0);
    n_gate = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (gate) n_gate++;
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort_no_gate", n_gate, 0);
    check("abort_no_done", n_done, 0);
    sb_en = 1'b1;

    // Pulse spanning the tnow wrap.
    wait_tnow(1010);
    push_cmd(1022, 5, 7, 1'b1, 1'b1, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
